// File: rtl/adder_subtractor_control.sv
// Operand-handshake controller for an external 8-bit add/subtract datapath.
// Optional signed-overflow flag is compiled in with `define OVERFLOW_DETECT_EN.
module adder_subtractor_control (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] inbus,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] dp_inbus_a,
    output logic [7:0] dp_inbus_b,
    output logic       dp_sub,
    output logic       dp_load,
    input  logic [7:0] dp_outbus,
    output logic [7:0] outbus,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
`ifdef OVERFLOW_DETECT_EN
    ,
    output logic       overflow
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_A  = 3'd1,
        GET_B  = 3'd2,
        EXEC   = 3'd3,
        CAPT   = 3'd4,
        RESULT = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_sub;
    logic [7:0] r_out;
    logic       w_xfer;

    assign w_xfer = in_valid && in_ready;

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        dp_load      = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_state_next = GET_A;
            end
            GET_A: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = GET_B;
            end
            GET_B: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = EXEC;
            end
            EXEC: begin
                dp_load      = 1'b1;
                w_state_next = CAPT;
            end
            CAPT: begin
                w_state_next = RESULT;
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_sub   <= 1'b0;
            r_out   <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && start) r_sub <= op;
            if (r_state == GET_A && w_xfer) r_a <= inbus;
            if (r_state == GET_B && w_xfer) r_b <= inbus;
            if (r_state == CAPT) r_out <= dp_outbus;
        end
    end

`ifdef OVERFLOW_DETECT_EN
    logic r_ovf;
    logic w_ovf_next;

    // Subtract overflows when operand signs differ, add when they match.
    always_comb begin
        w_ovf_next = 1'b0;
        if (r_sub) w_ovf_next = (r_a[7] != r_b[7]) && (dp_outbus[7] != r_a[7]);
        else       w_ovf_next = (r_a[7] == r_b[7]) && (dp_outbus[7] != r_a[7]);
    end

    always_ff @(posedge clk) begin
        if (reset)                r_ovf <= 1'b0;
        else if (r_state == CAPT) r_ovf <= w_ovf_next;
    end

    assign overflow = r_ovf;
`endif

    assign dp_inbus_a = r_a;
    assign dp_inbus_b = r_b;
    assign dp_sub     = r_sub;
    assign outbus     = r_out;

endmodule

// File: tb/tb_adder_subtractor_control.sv
// Bench for adder_subtractor_control with a behavioural registered adder datapath.
module tb_adder_subtractor_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] inbus = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dp_inbus_a;
    logic [7:0] dp_inbus_b;
    logic       dp_sub;
    logic       dp_load;
    logic [7:0] dp_outbus = 8'h00;
    logic [7:0] outbus;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
`ifdef OVERFLOW_DETECT_EN
    logic       overflow;
`endif

    adder_subtractor_control dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .inbus(inbus),
        .in_valid(in_valid), .in_ready(in_ready), .dp_inbus_a(dp_inbus_a),
        .dp_inbus_b(dp_inbus_b), .dp_sub(dp_sub), .dp_load(dp_load),
        .dp_outbus(dp_outbus), .outbus(outbus), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
`ifdef OVERFLOW_DETECT_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    // Datapath model: registered modulo-256 add or subtract on dp_load.
    always @(posedge clk) begin
        if (dp_load) dp_outbus <= dp_sub ? (dp_inbus_a - dp_inbus_b) : (dp_inbus_a + dp_inbus_b);
    end

    int load_cnt = 0;
    always @(posedge clk) begin
        if (dp_load) load_cnt <= load_cnt + 1;
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] sb_out[$];
    logic       sb_ovf[$];

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       ovf;
        int         b_stall;
        int         r_stall;
        logic       poke;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_a"}, dp_inbus_a, 0);
        chk({tag, "_b"}, dp_inbus_b, 0);
        chk({tag, "_sub"}, dp_sub, 0);
        chk({tag, "_outbus"}, outbus, 0);
        chk({tag, "_ctl"}, {dp_load, in_ready, out_valid, busy}, 0);
`ifdef OVERFLOW_DETECT_EN
        chk({tag, "_ovf"}, overflow, 0);
`endif
    endtask

    task automatic do_op(input int idx, input vec_t v);
        int lat;
        int total;
        int loads0;
        logic [7:0] exp_out;
        logic       exp_ovf;
        start = 1'b1; op = v.op; total = 0;
        @(negedge clk); total++;
        start = 1'b0; op = ~v.op;
        chk("ready_get_a", in_ready, 1);
        inbus = v.a; in_valid = 1'b1;
        @(negedge clk); total++;
        for (int i = 0; i < v.b_stall; i++) begin
            in_valid = 1'b0; inbus = 8'hA5;
            start = v.poke && (i == 0); op = ~v.op;
            @(negedge clk); total++;
            start = 1'b0;
            chk("stall_get_b", {in_ready, busy, dp_load}, 3'b110);
        end
        inbus = v.b; in_valid = 1'b1;
        loads0 = load_cnt;
        sb_out.push_back(v.res);
        sb_ovf.push_back(v.ovf);
        @(negedge clk); total++;
        in_valid = 1'b0;
        chk("load_in_exec", dp_load, 1);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk); total++; lat++;
        end
        chk("latency_b_to_valid", lat, 2);
        if (v.b_stall == 0) chk("start_to_valid", total, 5);
        for (int i = 0; i < v.r_stall; i++) begin
            @(negedge clk);
            chk("stall_result", {out_valid, outbus}, {1'b1, v.res});
        end
        out_ready = 1'b1;
        exp_out = sb_out.pop_front();
        exp_ovf = sb_ovf.pop_front();
        chk("outbus", outbus, exp_out);
`ifdef OVERFLOW_DETECT_EN
        chk("overflow", overflow, exp_ovf);
`endif
        chk("operands_stable", {dp_sub, dp_inbus_a, dp_inbus_b}, {v.op, v.a, v.b});
        chk("single_load", load_cnt - loads0, 1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_accept", {out_valid, busy}, 2'b00);
        $display("op %0d: sub=%0d a=%02h b=%02h -> out=%02h exp=%02h ovf_exp=%0d lat=%0d",
                 idx, v.op, v.a, v.b, outbus, exp_out, exp_ovf, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 0, 0, 1'b0};
        vecs[1] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 0, 0, 1'b0};
        vecs[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 0, 1, 1'b0};
        vecs[3] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b1, 0, 0, 1'b0};
        vecs[4] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b0, 0, 0, 1'b0};
        vecs[5] = '{1'b1, 8'h00, 8'h80, 8'h80, 1'b1, 0, 0, 1'b0};
        vecs[6] = '{1'b0, 8'h40, 8'h3C, 8'h7C, 1'b0, 3, 4, 1'b0};
        vecs[7] = '{1'b0, 8'h10, 8'h22, 8'h32, 1'b0, 2, 0, 1'b1};
        vecs[8] = '{1'b1, 8'h90, 8'h20, 8'h70, 1'b1, 2, 0, 1'b1};

        @(negedge clk);
        chk_reset_vals("in_reset");
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("after_reset");
        @(negedge clk);
        chk("idle_hold", busy, 0);

        // Back-to-back: each operation starts in the IDLE cycle after the last accept.
        for (int i = 0; i < 9; i++) do_op(i, vecs[i]);

        // Reset while in EXEC discards the operation.
        start = 1'b1; op = 1'b1;
        @(negedge clk); start = 1'b0; inbus = 8'h33; in_valid = 1'b1;
        @(negedge clk); inbus = 8'h44;
        @(negedge clk); in_valid = 1'b0;
        chk("exec_before_reset", dp_load, 1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk_reset_vals("rst_exec");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_valid_after_rst_exec", {out_valid, busy}, 2'b00);
        end
        $display("reset in EXEC: busy=%0d out_valid=%0d", busy, out_valid);

        // Reset while holding in RESULT.
        start = 1'b1; op = 1'b0;
        @(negedge clk); start = 1'b0; inbus = 8'h11; in_valid = 1'b1;
        @(negedge clk); inbus = 8'h22;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("result_before_reset", {out_valid, outbus}, {1'b1, 8'h33});
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk_reset_vals("rst_result");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_valid_after_rst_result", {out_valid, busy}, 2'b00);
        end
        $display("reset in RESULT: busy=%0d out_valid=%0d", busy, out_valid);

        chk("scoreboard_empty", sb_out.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
